// File: rtl/seq_pkg.sv
// Shared types and defaults for the program sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int HALT_WORD   = 0;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_DEPTH   = 8;

endpackage

// File: rtl/program_store.sv
// Program word array: synchronous write, asynchronous read, cleared on reset.
// Latency: write visible the cycle after the strobe; read is combinational.
// Backpressure: none; writes are gated by the caller.
module program_store
    import seq_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PC_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/program_sequencer.sv
// Fetches program words in order and issues them to the control unit.
// Latency: start -> first instr_valid in 2 cycles; 2 cycles per instruction.
// Backpressure: instr_out/pc_out held in ISSUE until instr_ready.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int PC_W    = $clog2(DEPTH),
    parameter int WRAP    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc_out,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_addr,
    output logic               busy,
    output logic               halted
);

    // One extra bit so addresses can be range-checked against DEPTH for any DEPTH.
    localparam logic [PC_W:0]   DEPTH_X = (PC_W+1)'(DEPTH);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    state_t             state, state_nxt;
    logic [PC_W-1:0]    pc, pc_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic [PC_W-1:0]    pc_out_nxt;
    logic [INSTR_W-1:0] rd_data;
    logic               store_we;

    program_store #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .PC_W    (PC_W)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (store_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            instr_out <= '0;
            pc_out    <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr_out <= instr_nxt;
            pc_out    <= pc_out_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        store_we   = 1'b0;
        case (state)
            IDLE, HALT: begin
                store_we = load_en && ({1'b0, load_addr} < DEPTH_X);
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (rd_data == INSTR_W'(HALT_WORD)) begin
                    state_nxt = HALT;
                end else begin
                    instr_nxt  = rd_data;
                    pc_out_nxt = pc;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (jump_en) begin
                        if ({1'b0, jump_addr} < DEPTH_X) begin
                            pc_nxt    = jump_addr;
                            state_nxt = FETCH;
                        end else begin
                            state_nxt = HALT;
                        end
                    end else if (pc != LAST_PC) begin
                        pc_nxt    = pc + PC_W'(1);
                        state_nxt = FETCH;
                    end else if (WRAP != 0) begin
                        pc_nxt    = '0;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears them immediately.
    assign instr_valid = (state == ISSUE);
    assign busy        = (state == FETCH) || (state == ISSUE);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: main instance (DEPTH 8, no wrap)
// plus two DEPTH 5 instances (wrap / no wrap) sharing load and handshake inputs.
module tb_program_sequencer;

    localparam logic [31:0] WA = 32'h1111_0001;
    localparam logic [31:0] WB = 32'h2222_0002;
    localparam logic [31:0] WC = 32'h3333_0003;
    localparam logic [31:0] WD = 32'hDDDD_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        start = 1'b0;
    logic        start5 = 1'b0;
    logic        instr_ready = 1'b0;
    logic        jump_en = 1'b0;
    logic [2:0]  jump_addr = '0;

    logic [31:0] instr_out, w_instr, n_instr;
    logic        instr_valid, w_valid, n_valid;
    logic [2:0]  pc_out, w_pc, n_pc;
    logic        busy, w_busy, n_busy;
    logic        halted, w_halted, n_halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_sequencer #(.INSTR_W(32), .DEPTH(8), .WRAP(0)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc_out(pc_out), .jump_en(jump_en), .jump_addr(jump_addr), .busy(busy), .halted(halted));

    program_sequencer #(.INSTR_W(32), .DEPTH(5), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start5), .instr_out(w_instr), .instr_valid(w_valid), .instr_ready(instr_ready),
        .pc_out(w_pc), .jump_en(jump_en), .jump_addr(jump_addr), .busy(w_busy), .halted(w_halted));

    program_sequencer #(.INSTR_W(32), .DEPTH(5), .WRAP(0)) dut_n (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start5), .instr_out(n_instr), .instr_valid(n_valid), .instr_ready(instr_ready),
        .pc_out(n_pc), .jump_en(jump_en), .jump_addr(jump_addr), .busy(n_busy), .halted(n_halted));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [2:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({instr_out, pc_out, instr_valid, busy, halted} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got instr=%h pc=%0d v=%0b busy=%0b halt=%0b want all 0",
                     instr_out, pc_out, instr_valid, busy, halted);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b halted=%0b want 0 0", busy, halted);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] words [3];
        words[0] = WA; words[1] = WB; words[2] = WC;
        load_word(3'd0, WA);
        load_word(3'd1, WB);
        load_word(3'd2, WC);
        load_word(3'd3, 32'h0);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_fetch: got busy=%0b valid=%0b want 1 0", busy, instr_valid);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== words[k] || pc_out !== 3'(k)) begin
                errors++;
                $display("FAIL seq_issue%0d: got v=%0b instr=%h pc=%0d want 1 %h %0d",
                         k, instr_valid, instr_out, pc_out, words[k], k);
            end
            tick();
            checks++;
            if (instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_drop%0d: got valid=%0b want 0", k, instr_valid);
            end
        end
        tick();
        checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || dut.pc !== 3'd3) begin
            errors++;
            $display("FAIL seq_halt: got halted=%0b busy=%0b pc=%0d want 1 0 3", halted, busy, dut.pc);
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== WA || pc_out !== 3'd0) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%0b instr=%h pc=%0d want 1 %h 0",
                         i, instr_valid, instr_out, pc_out, WA);
            end
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got valid=%0b want 0", instr_valid);
        end
        for (int i = 0; i < 40 && !halted; i++) tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL stall_end_halt: got halted=%0b want 1", halted);
        end
    endtask

    task automatic test_jump();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();  // ISSUE pc 0
        tick();
        tick();  // ISSUE pc 1
        tick();
        tick();  // ISSUE pc 2
        checks++;
        if (pc_out !== 3'd2 || instr_out !== WC) begin
            errors++;
            $display("FAIL jump_pre: got pc=%0d instr=%h want 2 %h", pc_out, instr_out, WC);
        end
        jump_en   = 1'b1;
        jump_addr = 3'd0;
        tick();
        jump_en = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 3'd0 || instr_out !== WA) begin
            errors++;
            $display("FAIL jump_target: got v=%0b pc=%0d instr=%h want 1 0 %h",
                     instr_valid, pc_out, instr_out, WA);
        end
        tick();
        tick();
        checks++;
        if (pc_out !== 3'd1 || instr_out !== WB) begin
            errors++;
            $display("FAIL jump_repeat: got pc=%0d instr=%h want 1 %h", pc_out, instr_out, WB);
        end
        for (int i = 0; i < 40 && !halted; i++) tick();
        checks++;
        if (halted !== 1'b1 || dut.pc !== 3'd3) begin
            errors++;
            $display("FAIL jump_halt: got halted=%0b pc=%0d want 1 3", halted, dut.pc);
        end
    endtask

    task automatic test_wrap();
        int exp_pc [7] = '{0, 1, 2, 3, 4, 0, 1};
        for (int a = 0; a < 5; a++) load_word(3'(a), 32'h5000_0001 + 32'(a));
        instr_ready = 1'b1;
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (w_valid !== 1'b1 || w_pc !== 3'(exp_pc[k]) || w_instr !== 32'h5000_0001 + 32'(exp_pc[k])) begin
                errors++;
                $display("FAIL wrap_issue%0d: got v=%0b pc=%0d instr=%h want 1 %0d %h",
                         k, w_valid, w_pc, w_instr, exp_pc[k], 32'h5000_0001 + 32'(exp_pc[k]));
            end
            if (k < 5) begin
                checks++;
                if (n_valid !== 1'b1 || n_pc !== 3'(k)) begin
                    errors++;
                    $display("FAIL nowrap_issue%0d: got v=%0b pc=%0d want 1 %0d", k, n_valid, n_pc, k);
                end
            end
            if (k == 6) begin
                jump_en   = 1'b1;
                jump_addr = 3'd6;
            end
            tick();
            jump_en = 1'b0;
            if (k == 4) begin
                checks++;
                if (n_halted !== 1'b1 || w_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_last: got nowrap_halted=%0b wrap_busy=%0b want 1 1", n_halted, w_busy);
                end
            end
            if (k == 6) begin
                checks++;
                if (w_halted !== 1'b1) begin
                    errors++;
                    $display("FAIL jump_oob_halt: got halted=%0b want 1", w_halted);
                end
            end
        end
    endtask

    task automatic test_load_guard();
        load_word(3'd0, WA);
        load_word(3'd1, WB);
        load_word(3'd2, 32'h0);
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();  // ISSUE A
        load_word(3'd1, WD);
        instr_ready = 1'b1;
        tick();  // handshake -> FETCH
        tick();
        checks++;
        if (pc_out !== 3'd1 || instr_out !== WB) begin
            errors++;
            $display("FAIL load_busy_ignored: got pc=%0d instr=%h want 1 %h", pc_out, instr_out, WB);
        end
        tick();
        tick();
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL load_halt: got halted=%0b want 1", halted);
        end
        load_en   = 1'b1;
        load_addr = 3'd1;
        load_data = WD;
        start     = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        tick();  // ISSUE A
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc_out !== 3'd1 || instr_out !== WD) begin
            errors++;
            $display("FAIL load_in_halt: got v=%0b pc=%0d instr=%h want 1 1 %h",
                     instr_valid, pc_out, instr_out, WD);
        end
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_out, pc_out, instr_valid, busy, halted} !== '0) begin
            errors++;
            $display("FAIL reset_async: got instr=%h pc=%0d v=%0b busy=%0b halt=%0b want all 0",
                     instr_out, pc_out, instr_valid, busy, halted);
        end
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || dut.pc !== 3'd0) begin
            errors++;
            $display("FAIL reset_restart: got busy=%0b pc=%0d want 1 0", busy, dut.pc);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0 || dut.pc !== 3'd0) begin
            errors++;
            $display("FAIL reset_cleared_halt: got halted=%0b v=%0b pc=%0d want 1 0 0",
                     halted, instr_valid, dut.pc);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_jump();
        test_wrap();
        test_load_guard();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Parametrised instruction sequencer. It holds a loadable program store of DEPTH words and fetches them in order under a clocked program counter. Each word is issued to the control unit over a valid/ready handshake. An all-zero word halts execution. The block adds jump redirection and an optional wrap-around mode, and replaces the fixed eight-slot, unclocked fetch chain in front of the control unit.

## Interface
Parameters:
- INSTR_W, 32, instruction word width in bits
- DEPTH, 8, number of program words (2..256)
- PC_W, $clog2(DEPTH), program counter width
- WRAP, 0, 0 = halt after the last word; 1 = continue at address 0

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_en  in  1  write strobe for the program store
- load_addr  in  PC_W  write address
- load_data  in  INSTR_W  write data
- start  in  1  begin execution at address 0; accepted only in IDLE or HALT
- instr_out  out  INSTR_W  issued instruction
- instr_valid  out  1  instr_out is valid
- instr_ready  in  1  control unit accepts instr_out
- pc_out  out  PC_W  address of the word in instr_out
- jump_en  in  1  redirect request; sampled only on a handshake
- jump_addr  in  PC_W  redirect target
- busy  out  1  high in FETCH or ISSUE
- halted  out  1  high in HALT

## Operation
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: start=1 sets pc to 0 and moves to FETCH.
- FETCH: reads mem[pc].
  - Word == 0: go to HALT. Nothing is issued and pc holds the address of the zero word.
  - Word != 0: register the word into instr_out, set pc_out = pc, go to ISSUE.
- ISSUE: instr_valid = 1. instr_out and pc_out stay stable until instr_valid & instr_ready.
- On a handshake:
  - jump_en = 1: pc becomes jump_addr and the state moves to FETCH. A jump_addr >= DEPTH moves to HALT instead.
  - jump_en = 0 and pc < DEPTH-1: pc becomes pc+1 and the state moves to FETCH.
  - jump_en = 0 and pc == DEPTH-1: WRAP=1 sets pc to 0 and moves to FETCH. WRAP=0 moves to HALT.
- HALT: start=1 sets pc to 0 and moves to FETCH. Otherwise the state holds.
- Loads:
  - A write is accepted only in IDLE or HALT. load_en in FETCH or ISSUE is ignored.
  - load_addr >= DEPTH is ignored.
- Arithmetic: pc increment is modulo 2^PC_W. The end-of-program check uses DEPTH-1 explicitly, so it is correct for non-power-of-2 DEPTH.

## Timing
- Reset values:
  - state IDLE, pc 0
  - instr_out 0, pc_out 0, instr_valid 0
  - busy 0, halted 0
  - all program words 0
- Start latency: start sampled at edge N gives FETCH after edge N and instr_valid = 1 after edge N+1.
- Throughput: 2 cycles per instruction minimum (ISSUE then FETCH) when instr_ready is held high.
- instr_valid deasserts on the edge that completes the handshake.
- instr_valid never drops without a handshake, except on reset.
- load_en and start in the same IDLE/HALT cycle: the write and the start take effect on the same edge. The following FETCH sees the new data.
- Reset mid-ISSUE: instr_valid drops immediately (asynchronously), and the program store clears.
- Outputs are registered. There is no combinational path from instr_ready to instr_valid.

## Structure
- Shared package seq_pkg holds:
  - state enum: IDLE, FETCH, ISSUE, HALT
  - constant HALT_WORD = 0
  - default widths INSTR_W and DEPTH
- Sub-module program_store:
  - DEPTH x INSTR_W register array
  - one synchronous write port and one asynchronous read port
  - async clear on rst
- The top level contains the FSM, pc, and output registers.

## Test plan
- Load 3 nonzero words {A, B, C} at 0..2 and 0 at 3, start, instr_ready=1 → A, B, C issued on pc_out 0, 1, 2 every 2 cycles, then halted=1 with pc=3.
- Hold instr_ready=0 for 5 cycles during ISSUE of A → instr_out=A and instr_valid=1 remain stable, and pc_out stays 0.
- Raise jump_en with jump_addr=0 on the handshake of word 2 → the next issued pc_out is 0, and the loop repeats.
- DEPTH=5, WRAP=1, all words nonzero → pc_out sequence 0,1,2,3,4,0,1; with WRAP=0, halted after pc_out 4.
- Assert load_en to address 1 during ISSUE → the write is ignored and the readback on the next run is unchanged; a load in HALT then start → the new word is issued.
- Assert rst while instr_valid=1 → all outputs are 0 without waiting for a clock edge, the state is IDLE, and a new start re-fetches from 0 (the first word is 0 after the clear, so the block halts).
